// File: rtl/sd_clk_gen.sv
// SD card clock generator: derives a registered sd_clk from the system clock
// at an identification (slow) or transfer (fast) rate, with edge strobes for
// the command/data engines. Start, stop, pause and rate changes only happen
// at phase boundaries, so no phase is ever shorter than the active half period.
module sd_clk_gen #(
  parameter int unsigned SLOW_HALF = 30,
  parameter int unsigned FAST_HALF = 1,
  parameter int unsigned CNT_W     = 6
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  input  logic fast_i,
  input  logic hold_i,
  output logic sd_clk_o,
  output logic rise_o,
  output logic fall_o,
  output logic active_o,
  output logic fast_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_HALF - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_tc;
  logic             tc;
  logic             go;

  // Terminal count follows the latched rate, which only changes on LOW entry.
  always_comb begin
    half_tc = fast_o ? FAST_TC : SLOW_TC;
    tc      = (cnt == half_tc);
    go      = en_i & ~hold_i;
  end

  assign active_o = (state != IDLE);

  // Phase sequencer: IDLE -> LOW -> HIGH -> LOW ..., parking only after a full low phase.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      sd_clk_o <= 1'b0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
      fast_o   <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (go) begin
            state  <= LOW;
            fast_o <= fast_i;
          end
        end
        LOW: begin
          if (tc) begin
            cnt <= '0;
            if (go) begin
              state    <= HIGH;
              sd_clk_o <= 1'b1;
              rise_o   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (tc) begin
            state    <= LOW;
            cnt      <= '0;
            sd_clk_o <= 1'b0;
            fall_o   <= 1'b1;
            fast_o   <= fast_i;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          sd_clk_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed testbench for sd_clk_gen with hand-computed expectations.
module tb_sd_clk_gen;

  localparam int SLOW = 30;
  localparam int FAST = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic fast  = 1'b0;
  logic hold  = 1'b0;
  logic sd_clk, rise, fall, active, fast_q;

  int checks   = 0;
  int failures = 0;

  sd_clk_gen #(.SLOW_HALF(SLOW), .FAST_HALF(FAST), .CNT_W(6)) dut (
    .clk_i    (clk),
    .rstn_i   (rst_n),
    .en_i     (en),
    .fast_i   (fast),
    .hold_i   (hold),
    .sd_clk_o (sd_clk),
    .rise_o   (rise),
    .fall_o   (fall),
    .active_o (active),
    .fast_o   (fast_q)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and observe just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Number of consecutive observed cycles with sd_clk unchanged, starting now.
  task automatic measure(output int len);
    logic start;
    start = sd_clk;
    len = 0;
    while (sd_clk == start && len < 500) begin
      len++;
      step();
    end
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!rise && n < 500) begin
      step();
      n++;
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, len, nrise, nfall, nhigh, nboth, nact, nedge;

    // Reset with en held high and fast requested: everything stays 0.
    en = 1'b1; fast = 1'b1; hold = 1'b0; rst_n = 1'b0;
    #23;
    check("rst_sd_clk", int'(sd_clk), 0);
    check("rst_rise",   int'(rise),   0);
    check("rst_fall",   int'(fall),   0);
    check("rst_active", int'(active), 0);
    check("rst_fast",   int'(fast_q), 0);

    // Release; next edge is edge 0 with go true.
    fast = 1'b0; rst_n = 1'b1;
    step();
    check("start_active", int'(active), 1);
    check("start_sd_clk", int'(sd_clk), 0);
    check("start_fast",   int'(fast_q), 0);
    wait_rise(n);
    check("first_rise_latency", n, SLOW);
    check("first_rise_sd_clk", int'(sd_clk), 1);
    check("first_rise_fall", int'(fall), 0);

    // One full slow period from the rise cycle.
    nrise = 0; nfall = 0; nhigh = 0; nboth = 0;
    for (int i = 0; i < 2 * SLOW; i++) begin
      if (rise) nrise++;
      if (fall) nfall++;
      if (sd_clk) nhigh++;
      if (rise && fall) nboth++;
      step();
    end
    check("slow_rises", nrise, 1);
    check("slow_falls", nfall, 1);
    check("slow_high_cycles", nhigh, SLOW);
    check("slow_both_strobes", nboth, 0);
    check("slow_period_rise", int'(rise), 1);
    measure(len);
    check("slow_high_len", len, SLOW);
    check("slow_fall_strobe", int'(fall), 1);
    measure(len);
    check("slow_low_len", len, SLOW);
    check("slow_rise_strobe", int'(rise), 1);

    // Rate switch at cycle 10 of a slow high phase.
    repeat (10) step();
    fast = 1'b1;
    measure(len);
    check("switch_high_rest", len, SLOW - 10);
    check("switch_fall", int'(fall), 1);
    check("switch_fast_q", int'(fast_q), 1);
    measure(len);
    check("fast_low_len", len, FAST);
    measure(len);
    check("fast_high_len", len, FAST);

    // Pause during a fast high phase.
    n = 0;
    while (!sd_clk && n < 10) begin step(); n++; end
    check("pause_at_high", int'(sd_clk), 1);
    hold = 1'b1;
    step();
    check("pause_fall", int'(fall), 1);
    check("pause_low_active", int'(active), 1);
    step();
    check("pause_idle_active", int'(active), 0);
    check("pause_idle_sd_clk", int'(sd_clk), 0);
    repeat (3) step();
    check("pause_parked_active", int'(active), 0);
    check("pause_parked_sd_clk", int'(sd_clk), 0);
    hold = 1'b0;
    step();
    check("resume_active", int'(active), 1);
    check("resume_no_rise_yet", int'(rise), 0);
    step();
    check("resume_rise", int'(rise), 1);
    check("resume_sd_clk", int'(sd_clk), 1);

    // Back to slow, then stop mid low phase.
    fast = 1'b0;
    step();
    check("slow_again_fall", int'(fall), 1);
    check("slow_again_fast_q", int'(fast_q), 0);
    repeat (10) step();
    en = 1'b0;
    nact = 0; nedge = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (active) nact++;
      if (rise || fall || sd_clk) nedge++;
    end
    check("stop_low_rest", nact, SLOW - 11);
    check("stop_no_edges", nedge, 0);
    check("stop_idle", int'(active), 0);

    // Restart, with a short en drop before terminal count: no stop.
    en = 1'b1;
    step();
    check("restart_active", int'(active), 1);
    repeat (5) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    measure(len);
    check("blip_low_rest", len, SLOW - 8);
    check("blip_rise", int'(rise), 1);

    // Asynchronous reset mid high phase.
    repeat (5) step();
    check("pre_reset_high", int'(sd_clk), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sd_clk", int'(sd_clk), 0);
    check("async_rst_active", int'(active), 0);
    en = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_active", int'(active), 0);
    check("post_rst_sd_clk", int'(sd_clk), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
